ps2_key_decoder: RTL

- Receives PS/2 keyboard frames and drives the game's active-low w/a/s/d level inputs.
- Each output is held low while its key is held and released on the break code.
- Sits at the board pin edge, in front of the PacMan top-level key inputs, in the clk_25MHz domain.
- Also exposes raw scan codes and frame errors for debug and seven-segment use.

---
 rtl/ps2_defs.sv | 26 ++
 rtl/ps2_rx_frame.sv | 140 ++++++++++++++
 rtl/ps2_key_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ps2_defs.sv
// ps2_defs: shared constants for the PS/2 keyboard front end.
//   - Set-2 scan codes for the four movement keys, the break/extended
//     prefixes, and the extended arrow codes (only used when the
//     PS2_ARROW_KEYS_EN macro is defined).
//   - FSM state encoding for the frame receiver.
package ps2_defs;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 frame receiver.
//   Synchronises the raw PS/2 clock and data, debounces the clock, detects
//   falling edges and assembles 11-bit frames (start, 8 data LSB first, odd
//   parity, stop). A stalled frame is abandoned after TIMEOUT_CYCLES cycles
//   without a falling edge.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous reset, active-low
//   ps2_clk_i   raw PS/2 clock (asynchronous)
//   ps2_data_i  raw PS/2 data (asynchronous)
//   byte_o      received byte, valid with valid_o
//   valid_o     one-cycle pulse, good frame received
//   err_o       one-cycle pulse, parity/stop/timeout error
module ps2_rx_frame
  import ps2_defs::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] FCNT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT_CYCLES - 1);

  logic           clk_s1_q, clk_s2_q;
  logic           dat_s1_q, dat_s2_q;
  logic           filt_q, filt_prev_q;
  logic [FCW-1:0] fcnt_q;
  logic           fall;

  rx_state_e      state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shreg_q;
  logic           par_q;
  logic [TCW-1:0] to_cnt_q;
  logic [7:0]     byte_q;
  logic           valid_q;
  logic           err_q;

  // Synchronisers plus clock filter. The filter counts consecutive samples
  // that disagree with the current filtered level; any agreeing sample
  // restarts the count, so glitches shorter than FILTER_LEN are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_s1_q    <= ps2_clk_i;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data_i;
      dat_s2_q    <= dat_s1_q;
      filt_prev_q <= filt_q;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCNT_MAX) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FCW'(1);
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // Frame FSM with timeout. The timeout check takes priority only when no
  // edge arrives in the same cycle, so a last-moment edge keeps the frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == ST_IDLE || fall) to_cnt_q <= '0;
      else                            to_cnt_q <= to_cnt_q + TCW'(1);

      if (state_q != ST_IDLE && !fall && to_cnt_q == TO_MAX) begin
        err_q    <= 1'b1;
        state_q  <= ST_IDLE;
        to_cnt_q <= '0;
      end else if (fall) begin
        case (state_q)
          ST_IDLE: begin
            // A high start bit is a stray edge; stay idle silently.
            if (!dat_s2_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shreg_q   <= {dat_s2_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (dat_s2_q && (^{shreg_q, par_q})) begin
              valid_q <= 1'b1;
              byte_q  <= shreg_q;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard to active-low w/a/s/d game inputs.
//   Tracks the break (F0) and extended (E0) prefixes and holds each key
//   output low from make code to break code. Raw bytes and frame errors are
//   exported for debug / seven-segment display.
//   Build option: define PS2_ARROW_KEYS_EN to also map the extended arrow
//   keys onto the same four outputs (last event wins).
// Ports:
//   clk_25MHz   system/VGA clock
//   reset       asynchronous reset, active-low
//   ps2_clk     raw PS/2 clock
//   ps2_data    raw PS/2 data
//   w, a, s, d  active-low key levels
//   scan_code   last valid received byte
//   scan_valid  one-cycle pulse when scan_code updates
//   frame_err   one-cycle pulse on parity, stop or timeout error
module ps2_key_decoder
  import ps2_defs::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w,
  output logic       a,
  output logic       s,
  output logic       d,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_err;

  logic       w_q, a_q, s_q, d_q;
  logic       w_d, a_d, s_d, d_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic       vld_q, err_q;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i     (clk_25MHz),
    .rst_ni    (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .byte_o    (rx_byte),
    .valid_o   (rx_vld),
    .err_o     (rx_err)
  );

  // Key outputs take the value of brk: a make code (brk=0) presses, a
  // break code (brk=1) releases. Prefix state is dropped on any error so a
  // corrupted break never leaks into the next key.
  always_comb begin
    w_d    = w_q;
    a_d    = a_q;
    s_d    = s_q;
    d_d    = d_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    code_d = code_q;
    if (rx_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_vld) begin
      code_d = rx_byte;
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          case (rx_byte)
            SC_W:    w_d = brk_q;
            SC_A:    a_d = brk_q;
            SC_S:    s_d = brk_q;
            SC_D:    d_d = brk_q;
            default: ;
          endcase
        end
`ifdef PS2_ARROW_KEYS_EN
        else begin
          case (rx_byte)
            SC_UP:    w_d = brk_q;
            SC_LEFT:  a_d = brk_q;
            SC_DOWN:  s_d = brk_q;
            SC_RIGHT: d_d = brk_q;
            default:  ;
          endcase
        end
`endif
      end
    end
  end

  // Keys, scan_code and the status pulses all update on the same edge, so
  // the key level is already final in the scan_valid cycle.
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      w_q    <= 1'b1;
      a_q    <= 1'b1;
      s_q    <= 1'b1;
      d_q    <= 1'b1;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      code_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      w_q    <= w_d;
      a_q    <= a_d;
      s_q    <= s_d;
      d_q    <= d_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      code_q <= code_d;
      vld_q  <= rx_vld;
      err_q  <= rx_err;
    end
  end

  assign w          = w_q;
  assign a          = a_q;
  assign s          = s_q;
  assign d          = d_q;
  assign scan_code  = code_q;
  assign scan_valid = vld_q;
  assign frame_err  = err_q;

endmodule
